// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the serial add scheduler:
//   - state_t : scheduler FSM states (IDLE, SHIFT, DONE)
//   - rr_pick : round-robin pick of the first valid requester at or above a
//               pointer, wrapping at n
// -----------------------------------------------------------------------------
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Widest requester vector rr_pick can search; callers zero-extend to this.
    localparam int RR_MAX = 32;

    // Returns the index of the first set bit of vld, starting at ptr and
    // wrapping at n. Returns ptr when no bit is set; callers qualify the
    // result with |vld. Walking k downward lets the smallest distance from
    // ptr win the last assignment.
    function automatic int rr_pick(input logic [RR_MAX-1:0] vld,
                                   input int ptr,
                                   input int n);
        int idx;
        int pick;
        pick = ptr;
        for (int k = RR_MAX - 1; k >= 0; k--) begin
            idx = ptr + k;
            if (idx >= n) begin
                idx = idx - n;
            end else begin
                idx = idx;
            end
            if ((k < n) && vld[idx]) begin
                pick = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/serial_add_core.sv
// -----------------------------------------------------------------------------
// serial_add_core
// One-bit serial full adder with a carry flop.
//   clk, rst  : clock and synchronous active-high reset
//   vld       : a bit pair is presented this cycle
//   a, b      : operand bits (LSB first across an operation)
//   last      : this is the final (MSB) bit of the operation
//   sum       : combinational sum bit  a ^ b ^ carry
//   carry_out : combinational full-adder carry for this bit
// The carry flop is only advanced on vld cycles and is cleared after the last
// bit so that no carry survives into the next operation.
// -----------------------------------------------------------------------------
module serial_add_core (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    input  logic a,
    input  logic b,
    input  logic last,
    output logic sum,
    output logic carry_out
);

    logic carry_r;

    // Full-adder sum and carry for the bit currently presented.
    always_comb begin
        sum       = a ^ b ^ carry_r;
        carry_out = (a & b) | (carry_r & (a ^ b));
    end

    // Carry state: cleared at the end of every operation, held while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_r <= 1'b0;
        end else if (vld && last) begin
            carry_r <= 1'b0;
        end else if (vld) begin
            carry_r <= carry_out;
        end else begin
            carry_r <= carry_r;
        end
    end

endmodule

// File: rtl/serial_add_scheduler.sv
// -----------------------------------------------------------------------------
// serial_add_scheduler
// Shares one bit-serial adder between N_REQ requesters.
//   clk, rst   : clock and synchronous active-high reset
//   req_vld    : per-requester operand valid
//   req_a/b    : packed operands, requester i in [i*WIDTH +: WIDTH]
//   req_rdy    : one-hot combinational grant (IDLE only)
//   res_vld    : registered result valid, held until res_rdy
//   res_rdy    : result consumer ready
//   res_sum    : registered sum modulo 2^WIDTH
//   res_carry  : registered carry out of the MSB
//   res_id     : registered index of the requester owning the result
//   busy       : registered, high while in SHIFT or DONE
// Timing: grant in cycle T, bits fed in T+1..T+WIDTH, res_vld in T+WIDTH+1.
// -----------------------------------------------------------------------------
module serial_add_scheduler
    import serial_add_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N_REQ = 2,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_vld,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_rdy,
    output logic                   res_vld,
    input  logic                   res_rdy,
    output logic [WIDTH-1:0]       res_sum,
    output logic                   res_carry,
    output logic [ID_W-1:0]        res_id,
    output logic                   busy
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

    state_t             state_r;
    logic [ID_W-1:0]    rr_ptr_r;
    logic [ID_W-1:0]    id_r;
    logic [ID_W-1:0]    pick_s;
    logic [ID_W-1:0]    ptr_next_s;
    logic               grant_s;
    logic [N_REQ-1:0]   req_rdy_s;
    logic [WIDTH-1:0]   sel_a_s;
    logic [WIDTH-1:0]   sel_b_s;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-1:0]   a_sh_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               core_vld_s;
    logic               core_last_s;
    logic               core_sum_s;
    logic               core_cout_s;
    logic [WIDTH-1:0]   res_sum_r;
    logic               res_carry_r;
    logic [ID_W-1:0]    res_id_r;
    logic               res_vld_r;
    logic               busy_r;

    // Round-robin arbitration; a grant is only offered in IDLE.
    always_comb begin
        pick_s  = ID_W'(rr_pick(RR_MAX'(req_vld), int'(rr_ptr_r), N_REQ));
        grant_s = (state_r == IDLE) && (|req_vld);
        if (grant_s) begin
            req_rdy_s = N_REQ'(1'b1) << pick_s;
        end else begin
            req_rdy_s = '0;
        end
        if (pick_s == ID_LAST) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = pick_s + ID_W'(1);
        end
    end

    // AND-OR operand mux selecting the granted requester's pair.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_a_s = sel_a_s | ({WIDTH{pick_s == ID_W'(i)}} & req_a[i*WIDTH +: WIDTH]);
            sel_b_s = sel_b_s | ({WIDTH{pick_s == ID_W'(i)}} & req_b[i*WIDTH +: WIDTH]);
        end
    end

    // Core sequencing. Sum bits enter a_sh at the top while operand bits leave
    // at the bottom, so after WIDTH shifts a_sh holds the complete result.
    always_comb begin
        core_vld_s  = (state_r == SHIFT);
        core_last_s = core_vld_s && (cnt_r == CNT_LAST);
        a_sh_next_s = {core_sum_s, a_sh_r[WIDTH-1:1]};
    end

    serial_add_core u_core (
        .clk       (clk),
        .rst       (rst),
        .vld       (core_vld_s),
        .a         (a_sh_r[0]),
        .b         (b_sh_r[0]),
        .last      (core_last_s),
        .sum       (core_sum_s),
        .carry_out (core_cout_s)
    );

    // Scheduler FSM, operand/result shifting and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            rr_ptr_r    <= '0;
            id_r        <= '0;
            a_sh_r      <= '0;
            b_sh_r      <= '0;
            cnt_r       <= '0;
            res_sum_r   <= '0;
            res_carry_r <= 1'b0;
            res_id_r    <= '0;
            res_vld_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        a_sh_r   <= sel_a_s;
                        b_sh_r   <= sel_b_s;
                        id_r     <= pick_s;
                        cnt_r    <= '0;
                        rr_ptr_r <= ptr_next_s;
                        busy_r   <= 1'b1;
                        state_r  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh_r <= a_sh_next_s;
                    b_sh_r <= b_sh_r >> 1;
                    cnt_r  <= cnt_r + CNT_W'(1);
                    if (core_last_s) begin
                        res_sum_r   <= a_sh_next_s;
                        res_carry_r <= core_cout_s;
                        res_id_r    <= id_r;
                        res_vld_r   <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    if (res_rdy) begin
                        res_vld_r <= 1'b0;
                        busy_r    <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    res_vld_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign req_rdy   = req_rdy_s;
    assign res_vld   = res_vld_r;
    assign res_sum   = res_sum_r;
    assign res_carry = res_carry_r;
    assign res_id    = res_id_r;
    assign busy      = busy_r;

endmodule

// File: doc/serial_add_scheduler.md
Name: serial_add_scheduler

Overview:
- Shares one bit-serial adder core between N_REQ requesters.
- Accepts parallel operand pairs over a valid/ready handshake and arbitrates round-robin.
- Shifts the granted pair through the core LSB-first, driving the core's vld/last sequencing.
- Reassembles the sum bits into a parallel result, returned with the requester ID over a valid/ready handshake.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)
N_REQ, 2, number of requesters (>= 2)
ID_W, max(1,$clog2(N_REQ)), derived localparam, requester ID width

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous reset, active-high
req_vld  input  N_REQ  per-requester operand valid
req_a  input  N_REQ*WIDTH  operand A, requester i in bits [i*WIDTH +: WIDTH]
req_b  input  N_REQ*WIDTH  operand B, same packing
req_rdy  output  N_REQ  one-hot grant; transfer when req_vld[i] & req_rdy[i]
res_vld  output  1  result valid
res_rdy  input  1  result consumer ready
res_sum  output  WIDTH  sum modulo 2^WIDTH
res_carry  output  1  carry out of the MSB
res_id  output  ID_W  index of the requester that owns the result
busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset: synchronous, active-high (rst sampled on posedge clk).
  - State goes to IDLE; rr_ptr = 0; core carry = 0.
  - Shift registers, res_sum, res_carry, res_id and res_vld go to 0; busy = 0.
  - Reset mid-SHIFT or in DONE aborts the operation silently; no result is emitted.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - req_rdy is combinational: one-hot on the first i with req_vld[i]=1, searching from rr_ptr upward with wrap.
  - req_rdy is all-zero in IDLE when no request is valid, and all-zero in every other state.
  - On a transfer: latch a, b and id; bit counter = 0; rr_ptr = (granted + 1) mod N_REQ; go to SHIFT.
  - rr_ptr is unchanged when nothing is granted.
- SHIFT (exactly WIDTH cycles):
  - Each cycle drives the core with vld=1, a=a_sh[0], b=b_sh[0], last=(cnt==WIDTH-1).
  - The core sum bit shifts into the MSB of the result shift register; a_sh/b_sh shift right; cnt increments.
  - After the last bit: load res_sum from the shift register, load res_carry from the core carry-out, go to DONE.
- DONE:
  - res_vld = 1; res_sum, res_carry and res_id are held stable until res_vld & res_rdy.
  - The handshake cycle returns the FSM to IDLE. New grants start the following cycle, with no grant in the same cycle.
- Latency: grant in cycle T; bits are fed in T+1..T+WIDTH; res_vld rises in T+WIDTH+1.
  - With res_rdy held high, throughput is one op per WIDTH+2 cycles.
- Core carry:
  - Cleared on rst.
  - Cleared on a cycle with vld & last, after the carry-out is presented.
  - Updated only when vld=1, and held when vld=0.
  - No carry leaks between operations.
- Requester signals are ignored outside IDLE; requesters must hold req_vld and operands until granted.
- Simultaneous requests: exactly one grant per IDLE cycle.
- All outputs are registered except req_rdy.

Decomposition:
- Package serial_add_pkg holds:
  - the state_t enum (IDLE, SHIFT, DONE);
  - the function rr_pick(vld, ptr) returning the granted index.
- One sub-module, serial_add_core (ports clk, rst, vld, a, b, last, sum, carry_out):
  - sum = a^b^carry_q is combinational;
  - carry_out is the full-adder carry;
  - carry_q is updated per the carry rules above.

Test Plan:
- Single request, req0 with A=8'h3C, B=8'h05, grant at T -> res_sum=8'h41, res_carry=0, res_id=0, res_vld first high at T+9.
- Overflow then zero, 8'hFF+8'h01 then 8'h00+8'h00 -> first 8'h00 with carry=1, second 8'h00 with carry=0 (carry cleared between ops).
- Contention, req0 and req1 both held valid for 4 ops -> grants alternate 0,1,0,1; res_id matches each grant; no double grant.
- Backpressure, res_rdy low for 5 cycles in DONE -> res_vld and outputs stable, req_rdy=0, no new grant; grant occurs the cycle after the handshake.
- Reset at bit 4 of 8'hAA+8'h55 -> the next cycle shows res_vld=0, busy=0, req_rdy idle-correct and rr_ptr=0; a subsequent 8'h01+8'h01 yields 8'h02 with carry=0.
- WIDTH=4, N_REQ=3, with req2 only then all three -> first grant to 2; then the order is 0,1,2 (pointer wraps past 2 to 0).
